// File: rtl/pio_out_pkg.sv
// ---------------------------------------------------------------------------
// pio_out_pkg
// Shared constants for the blinking output PIO: the word-address width of the
// slave port and the offset of every register in its map.
// ---------------------------------------------------------------------------
package pio_out_pkg;

  // Width of the Avalon word address into the register file
  localparam int PIO_ADDR_W = 3;

  // Register word offsets
  localparam logic [PIO_ADDR_W-1:0] PIO_DATA     = 3'd0;
  localparam logic [PIO_ADDR_W-1:0] PIO_SET      = 3'd1;
  localparam logic [PIO_ADDR_W-1:0] PIO_CLEAR    = 3'd2;
  localparam logic [PIO_ADDR_W-1:0] PIO_TOGGLE   = 3'd3;
  localparam logic [PIO_ADDR_W-1:0] PIO_BLINK_EN = 3'd4;
  localparam logic [PIO_ADDR_W-1:0] PIO_PERIOD   = 3'd5;
  localparam logic [PIO_ADDR_W-1:0] PIO_STATUS   = 3'd6;

endpackage

// File: rtl/pio_blink_timer.sv
// ---------------------------------------------------------------------------
// pio_blink_timer
// Free-running half-period timer that produces the blink phase. The counter
// runs 0..period and flips the phase each time it wraps, so one full blink
// cycle lasts 2*(period+1) clocks.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (cnt=0, phase=1)
//   period   in   half-period minus one, in clocks
//   restart  in   restart the half-period: cnt=0, phase=1 (wins over a wrap)
//   phase    out  current blink phase, registered
// ---------------------------------------------------------------------------
module pio_blink_timer #(
  parameter int PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // A restart takes priority so that a new period always begins with a full
  // lit half-period, even when the old count would have wrapped this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pio_out_blink.sv
// ---------------------------------------------------------------------------
// pio_out_blink
// Avalon-MM output PIO for board indicators. Holds the output image with
// atomic set/clear/toggle access, a per-bit blink enable and a programmable
// blink half-period. Read data and the pins are combinational from flops.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   address     in   word address (see pio_out_pkg offsets)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data, bits above the register width ignored
//   readdata    out  combinational read data, zero-extended
//   out_port    out  indicator outputs
// ---------------------------------------------------------------------------
module pio_out_blink
  import pio_out_pkg::*;
#(
  parameter int                  WIDTH        = 9,
  parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
  parameter int                  PERIOD_W     = 26,
  parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(24999999)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIO_ADDR_W-1:0] address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [WIDTH-1:0]      out_port
);

  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    blink_en_q;
  logic [PERIOD_W-1:0] period_q;
  logic                phase;

  logic                wr_en;
  logic                period_wr;
  logic [WIDTH-1:0]    wd_bits;
  logic [PERIOD_W-1:0] wd_period;
  logic                unused_wd;
  logic [31:0]         rd;

  assign wr_en     = chipselect && !write_n;
  assign period_wr = wr_en && (address == PIO_PERIOD);
  assign wd_bits   = writedata[WIDTH-1:0];
  assign wd_period = writedata[PERIOD_W-1:0];

  // Upper writedata bits are deliberately dropped for narrow registers
  assign unused_wd = ^writedata;

  // Register file write decode; set/clear/toggle act on the current image
  // so software never needs a read-modify-write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= PERIOD_RESET;
    end else if (wr_en) begin
      case (address)
        PIO_DATA:     data_q     <= wd_bits;
        PIO_SET:      data_q     <= data_q | wd_bits;
        PIO_CLEAR:    data_q     <= data_q & ~wd_bits;
        PIO_TOGGLE:   data_q     <= data_q ^ wd_bits;
        PIO_BLINK_EN: blink_en_q <= wd_bits;
        PIO_PERIOD:   period_q   <= wd_period;
        default:      ;
      endcase
    end
  end

  // Writing the period restarts the timer so the new rate starts cleanly
  pio_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (period_wr),
    .phase   (phase)
  );

  // Read mux; write-only and unused offsets read as zero
  always_comb begin
    rd = '0;
    case (address)
      PIO_DATA:     rd[WIDTH-1:0]    = data_q;
      PIO_BLINK_EN: rd[WIDTH-1:0]    = blink_en_q;
      PIO_PERIOD:   rd[PERIOD_W-1:0] = period_q;
      PIO_STATUS:   rd[0]            = phase;
      default:      rd               = '0;
    endcase
    readdata = rd;
  end

  // Blinking bits are gated by the phase; a bit whose data is 0 stays dark
  assign out_port = (data_q & ~blink_en_q) | (data_q & blink_en_q & {WIDTH{phase}});

endmodule

// File: tb/tb_pio_out_blink.sv
// ---------------------------------------------------------------------------
// tb_pio_out_blink
// Scoreboard bench for pio_out_blink. Stimulus queues the expected readdata
// and out_port for each read (or mid-cycle pin probe); the monitor pops and
// compares whenever a read is presented or a probe is raised.
// ---------------------------------------------------------------------------
module tb_pio_out_blink;
  import pio_out_pkg::*;

  localparam int         WIDTH    = 9;
  localparam int         PERIOD_W = 26;
  localparam logic [8:0] RST_VAL  = 9'h0A5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  out_port;

  string             name_q[$];
  bit                chk_q[$];
  logic [31:0]       rd_q[$];
  logic [WIDTH-1:0]  out_q[$];

  int   checks = 0;
  int   errors = 0;
  event probe_ev;
  bit   probe_req = 1'b0;
  bit   final_req = 1'b0;

  pio_out_blink #(
    .WIDTH        (WIDTH),
    .RESET_VALUE  (RST_VAL),
    .PERIOD_W     (PERIOD_W),
    .PERIOD_RESET (26'd24999999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Issue one write that lands on the next rising edge
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Queue expectations and present a one-cycle read
  task automatic checkOutput(input string n, input logic [2:0] a,
                             input logic [31:0] erd, input logic [WIDTH-1:0] eout);
    name_q.push_back(n);
    chk_q.push_back(1'b1);
    rd_q.push_back(erd);
    out_q.push_back(eout);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  // Mid-cycle pin check that does not wait for any clock edge
  task automatic probeOutput(input string n, input logic [WIDTH-1:0] eout);
    name_q.push_back(n);
    chk_q.push_back(1'b0);
    rd_q.push_back('0);
    out_q.push_back(eout);
    probe_req = 1'b1;
    -> probe_ev;
    #1;
    probe_req = 1'b0;
  endtask

  // Monitor: compares queued expectations against the DUT
  initial begin : monitor
    string            n;
    bit               c;
    logic [31:0]      erd;
    logic [WIDTH-1:0] eout;
    forever begin
      @(negedge clk or probe_ev);
      if (final_req) begin
        checks++;
        if (name_q.size() != 0) begin
          errors++;
          $display("[TB] FAIL drain: %0d expectations never sampled, required 0", name_q.size());
        end
      end else if (probe_req || (chipselect && write_n)) begin
        if (name_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_sample: nothing queued, readdata=%h out_port=%h", readdata, out_port);
        end else begin
          n    = name_q.pop_front();
          c    = chk_q.pop_front();
          erd  = rd_q.pop_front();
          eout = out_q.pop_front();
          if (c) begin
            checks++;
            if (readdata !== erd) begin
              errors++;
              $display("[TB] FAIL %s readdata: got %h, expected %h", n, readdata, erd);
            end
          end
          checks++;
          if (out_port !== eout) begin
            errors++;
            $display("[TB] FAIL %s out_port: got %h, expected %h", n, out_port, eout);
          end
        end
      end
    end
  end

  // Watchdog so a hung run still terminates
  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bit ph;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;

    // Reset: asserted before any clock edge, pins must follow immediately
    #2;
    reset_n = 1'b0;
    #1;
    probeOutput("reset_pins_async", RST_VAL);
    @(posedge clk);
    #1;
    checkOutput("reset_data_in_reset", PIO_DATA, 32'h0000_00A5, RST_VAL);
    reset_n = 1'b1;
    checkOutput("reset_data", PIO_DATA, 32'h0000_00A5, RST_VAL);
    checkOutput("reset_status", PIO_STATUS, 32'h1, RST_VAL);
    checkOutput("reset_period", PIO_PERIOD, 32'd24999999, RST_VAL);
    checkOutput("reset_blink_en", PIO_BLINK_EN, 32'h0, RST_VAL);

    // Data image and atomic set/clear/toggle
    applyStimulus(PIO_DATA, 32'h0F0);
    checkOutput("data_wr", PIO_DATA, 32'h0F0, 9'h0F0);
    applyStimulus(PIO_SET, 32'h003);
    checkOutput("set", PIO_DATA, 32'h0F3, 9'h0F3);
    applyStimulus(PIO_CLEAR, 32'h010);
    checkOutput("clear", PIO_DATA, 32'h0E3, 9'h0E3);
    applyStimulus(PIO_TOGGLE, 32'h101);
    checkOutput("toggle", PIO_DATA, 32'h1E2, 9'h1E2);
    checkOutput("read_set_zero", PIO_SET, 32'h0, 9'h1E2);
    checkOutput("read_clear_zero", PIO_CLEAR, 32'h0, 9'h1E2);
    checkOutput("read_toggle_zero", PIO_TOGGLE, 32'h0, 9'h1E2);
    checkOutput("read_off7_zero", 3'd7, 32'h0, 9'h1E2);

    // Back-to-back writes on consecutive edges, then write to offset 7
    applyStimulus(PIO_SET, 32'h01C);
    applyStimulus(PIO_CLEAR, 32'h100);
    applyStimulus(3'd7, 32'hFFFF_FFFF);
    checkOutput("b2b_writes", PIO_DATA, 32'h0FE, 9'h0FE);

    // Upper writedata bits are dropped
    applyStimulus(PIO_DATA, 32'hFFFF_FFFF);
    checkOutput("data_trunc", PIO_DATA, 32'h1FF, 9'h1FF);
    applyStimulus(PIO_PERIOD, 32'hFFFF_FFFF);
    checkOutput("period_trunc", PIO_PERIOD, 32'h03FF_FFFF, 9'h1FF);

    // Blink with half-period of 4 clocks on bits [3:0]
    applyStimulus(PIO_BLINK_EN, 32'h00F);
    checkOutput("blink_en_rd", PIO_BLINK_EN, 32'h00F, 9'h1FF);
    applyStimulus(PIO_PERIOD, 32'd3);
    for (int k = 0; k < 16; k++) begin
      ph = ((k / 4) % 2) == 0;
      checkOutput($sformatf("blink_p3_k%0d", k), PIO_STATUS, {31'b0, ph}, ph ? 9'h1FF : 9'h1F0);
    end

    // PERIOD=0 toggles every clock
    applyStimulus(PIO_PERIOD, 32'd0);
    for (int k = 0; k < 4; k++) begin
      ph = (k % 2) == 0;
      checkOutput($sformatf("blink_p0_k%0d", k), PIO_STATUS, {31'b0, ph}, ph ? 9'h1FF : 9'h1F0);
    end

    // Rewrite PERIOD on an edge where the counter would wrap
    applyStimulus(PIO_PERIOD, 32'd5);
    for (int k = 0; k < 8; k++) begin
      ph = (k < 6);
      checkOutput($sformatf("restart_p5_k%0d", k), PIO_STATUS, {31'b0, ph}, ph ? 9'h1FF : 9'h1F0);
    end
    checkOutput("period_rd5", PIO_PERIOD, 32'd5, 9'h1F0);

    // Async reset while phase is low
    applyStimulus(PIO_PERIOD, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    probeOutput("phase_low_pins", 9'h1F0);
    #2;
    reset_n = 1'b0;
    #1;
    probeOutput("async_reset_pins", RST_VAL);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("post_reset_blink_en", PIO_BLINK_EN, 32'h0, RST_VAL);
    checkOutput("post_reset_data", PIO_DATA, 32'h0A5, RST_VAL);
    checkOutput("post_reset_status", PIO_STATUS, 32'h1, RST_VAL);
    checkOutput("post_reset_period", PIO_PERIOD, 32'd24999999, RST_VAL);

    // Let the monitor confirm every expectation was consumed
    repeat (2) @(posedge clk);
    #1;
    final_req = 1'b1;
    -> probe_ev;
    #1;
    final_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
